rsa_nl_responder: RTL and testbench

Responder end of the RSA nonlinear-evaluation handshake. RSA pulses init_predict / init_newlm / init_update and presents state operands. This block evaluates the EKF nonlinear functions in fixed point, then returns one done_* pulse with result_0..5. It replaces the bench-driven done/result stimulus and sits beside RSA in the EKF-SLAM top level.

---
 rtl/rsa_nl_responder_pkg.sv | 20 ++
 rtl/nl_sincos_lut.sv | 32 +++
 rtl/rsa_nl_responder.sv | 87 ++++++++
 tb/tb_rsa_nl_responder.sv | 120 ++++++++++++
 4 files changed

// File: rtl/rsa_nl_responder_pkg.sv
// rsa_nl_responder_pkg: shared widths, op codes, FSM states and fixed-point helpers
package rsa_nl_responder_pkg;
  localparam int RSA_DW = 16;
  localparam int FRAC = 8;
  localparam int TRIG_FRAC = 14;
  localparam int LUT_AW = 6;
  localparam logic [15:0] ANGLE_QUARTER = 16'h4000;
  typedef enum logic [1:0] {OP_PRD, OP_NEW, OP_UPD} op_e;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LUT = 3'd1;
  localparam logic [2:0] S_MUL = 3'd2;
  localparam logic [2:0] S_ACC = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;
  function automatic logic signed [33:0] sx(input logic [RSA_DW-1:0] v);
    return 34'(signed'(v));
  endfunction
  function automatic logic [RSA_DW-1:0] sat16(input logic signed [33:0] v);
    return v > 34'sd32767 ? 16'h7FFF : v < -34'sd32768 ? 16'h8000 : v[15:0];
  endfunction
endpackage

// File: rtl/nl_sincos_lut.sv
// nl_sincos_lut: registered Q1.14 sin/cos from a quarter-wave ROM with quadrant folding
module nl_sincos_lut
  import rsa_nl_responder_pkg::*;
(
  input  logic              clk,
  input  logic [7:0]        idx,
  output logic [RSA_DW-1:0] sin_v,
  output logic [RSA_DW-1:0] cos_v
);
  localparam logic [14:0] ROM [2**LUT_AW] = '{
    15'd0,     15'd402,   15'd804,   15'd1205,  15'd1606,  15'd2006,  15'd2404,  15'd2801,
    15'd3196,  15'd3590,  15'd3981,  15'd4370,  15'd4756,  15'd5139,  15'd5520,  15'd5897,
    15'd6270,  15'd6639,  15'd7005,  15'd7366,  15'd7723,  15'd8076,  15'd8423,  15'd8765,
    15'd9102,  15'd9434,  15'd9760,  15'd10080, 15'd10394, 15'd10702, 15'd11003, 15'd11297,
    15'd11585, 15'd11866, 15'd12140, 15'd12406, 15'd12665, 15'd12916, 15'd13160, 15'd13395,
    15'd13623, 15'd13842, 15'd14053, 15'd14256, 15'd14449, 15'd14635, 15'd14811, 15'd14978,
    15'd15137, 15'd15286, 15'd15426, 15'd15557, 15'd15679, 15'd15791, 15'd15893, 15'd15986,
    15'd16069, 15'd16143, 15'd16207, 15'd16261, 15'd16305, 15'd16340, 15'd16364, 15'd16379
  };
  // odd quadrants read the table mirrored; the mirror of entry 0 is exactly +1.0
  function automatic logic [RSA_DW-1:0] qsin(input logic [7:0] i);
    logic [LUT_AW-1:0] k;
    logic [RSA_DW-1:0] m;
    k = i[LUT_AW-1:0];
    m = i[LUT_AW] ? (k == '0 ? 16'h4000 : {1'b0, ROM[-k]}) : {1'b0, ROM[k]};
    return i[LUT_AW+1] ? -m : m;
  endfunction
  always_ff @(posedge clk) begin
    sin_v <= qsin(idx);
    cos_v <= qsin(idx + ANGLE_QUARTER[15:8]);
  end
endmodule

// File: rtl/rsa_nl_responder.sv
// rsa_nl_responder: evaluates EKF predict/new-landmark/update nonlinearities for RSA in 4 cycles
module rsa_nl_responder
  import rsa_nl_responder_pkg::*;
(
  input  logic              clk,
  input  logic              sys_rst,
  input  logic              init_predict,
  input  logic              init_newlm,
  input  logic              init_update,
  input  logic [RSA_DW-1:0] xk,
  input  logic [RSA_DW-1:0] yk,
  input  logic [RSA_DW-1:0] xita,
  input  logic [RSA_DW-1:0] lkx,
  input  logic [RSA_DW-1:0] lky,
  input  logic [RSA_DW-1:0] vdt,
  input  logic [RSA_DW-1:0] wdt,
  input  logic [RSA_DW-1:0] obs_r,
  input  logic [RSA_DW-1:0] obs_phi,
  output logic              done_predict,
  output logic              done_newlm,
  output logic              done_update,
  output logic [RSA_DW-1:0] result_0,
  output logic [RSA_DW-1:0] result_1,
  output logic [RSA_DW-1:0] result_2,
  output logic [RSA_DW-1:0] result_3,
  output logic [RSA_DW-1:0] result_4,
  output logic [RSA_DW-1:0] result_5,
  output logic              busy,
  output logic              err_overlap
);
  logic [2:0] state;
  op_e op;
  logic req, multi, cap, prd, upd;
  logic [RSA_DW-1:0] x, y, lx, ly, m, ang, w, pc, ps, dx, dy, sin_v, cos_v, q;
  logic [RSA_DW-1:0] a0, a1, a2, a3, a4;
  logic [24:0] sq;
  // round half up then drop the Q1.14 fraction
  function automatic logic [RSA_DW-1:0] mulq(input logic [RSA_DW-1:0] a, b);
    return sat16((sx(a) * sx(b) + 34'sd8192) >>> TRIG_FRAC);
  endfunction
  assign req = init_predict | init_newlm | init_update;
  assign multi = (init_predict & init_newlm) | (init_predict & init_update) | (init_newlm & init_update);
  assign busy = state != S_IDLE;
  assign cap = req & ~busy;
  assign prd = op == OP_PRD;
  assign upd = op == OP_UPD;
  assign sq = 25'((33'(32'(signed'(dx)) * 32'(signed'(dx))) + 33'(32'(signed'(dy)) * 32'(signed'(dy)))) >> FRAC);
  assign q = |sq[24:15] ? 16'h7FFF : sq[15:0];
  assign result_5 = '0;
  nl_sincos_lut u_lut (.clk(clk), .idx(ang[15:8]), .sin_v(sin_v), .cos_v(cos_v));
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      state <= S_IDLE;
      err_overlap <= 1'b0;
      {done_predict, done_newlm, done_update} <= '0;
      {result_0, result_1, result_2, result_3, result_4} <= '0;
    end else begin
      state <= state == S_IDLE ? (req ? S_LUT : S_IDLE) : state == S_DONE ? S_IDLE : state + 3'd1;
      err_overlap <= err_overlap | (req & busy) | multi;
      done_predict <= state == S_DONE && op == OP_PRD;
      done_newlm <= state == S_DONE && op == OP_NEW;
      done_update <= state == S_DONE && op == OP_UPD;
      if (state == S_DONE) {result_0, result_1, result_2, result_3, result_4} <= {a0, a1, a2, a3, a4};
    end
  end
  always_ff @(posedge clk) begin
    if (cap) begin
      op <= init_predict ? OP_PRD : init_newlm ? OP_NEW : OP_UPD;
      {x, y, lx, ly, w} <= {xk, yk, lkx, lky, wdt};
      m <= init_predict ? vdt : obs_r;
      ang <= init_predict ? xita : xita + obs_phi;
    end
    if (state == S_MUL) begin
      pc <= mulq(m, cos_v);
      ps <= mulq(m, sin_v);
      dx <= sat16(sx(lx) - sx(x));
      dy <= sat16(sx(ly) - sx(y));
    end
    if (state == S_ACC) begin
      a0 <= upd ? dx : sat16(sx(x) + sx(pc));
      a1 <= upd ? dy : sat16(sx(y) + sx(ps));
      a2 <= upd ? q : prd ? ang + w : ang;
      a3 <= upd ? '0 : prd ? sat16(-sx(ps)) : cos_v;
      a4 <= upd ? '0 : prd ? pc : sin_v;
    end
  end
endmodule

// File: tb/tb_rsa_nl_responder.sv
// tb_rsa_nl_responder: directed vectors with a scoreboard queue checked by a done-driven monitor
module tb_rsa_nl_responder;
  typedef logic [5:0][15:0] res_t;
  typedef struct {
    logic [2:0] d;
    res_t r;
    int due;
  } exp_t;
  logic clk = 1'b0;
  logic sys_rst, init_predict, init_newlm, init_update;
  logic [15:0] xk, yk, xita, lkx, lky, vdt, wdt, obs_r, obs_phi;
  logic done_predict, done_newlm, done_update, busy, err_overlap;
  logic [15:0] result_0, result_1, result_2, result_3, result_4, result_5;
  res_t got;
  exp_t sbq[$];
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  assign got = {result_5, result_4, result_3, result_2, result_1, result_0};
  rsa_nl_responder dut (
    .clk(clk), .sys_rst(sys_rst),
    .init_predict(init_predict), .init_newlm(init_newlm), .init_update(init_update),
    .xk(xk), .yk(yk), .xita(xita), .lkx(lkx), .lky(lky), .vdt(vdt), .wdt(wdt),
    .obs_r(obs_r), .obs_phi(obs_phi),
    .done_predict(done_predict), .done_newlm(done_newlm), .done_update(done_update),
    .result_0(result_0), .result_1(result_1), .result_2(result_2),
    .result_3(result_3), .result_4(result_4), .result_5(result_5),
    .busy(busy), .err_overlap(err_overlap)
  );
  task automatic chk(input string name, input logic [15:0] g, input logic [15:0] want);
    checks++;
    if (g !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, g, want);
    end
  endtask
  task automatic go(input logic [2:0] rq, input logic push, input logic [2:0] d, input res_t r);
    {init_predict, init_newlm, init_update} = rq;
    if (push) sbq.push_back('{d: d, r: r, due: cyc + 5});
    @(negedge clk);
    {init_predict, init_newlm, init_update} = '0;
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  always @(negedge clk) begin
    exp_t e;
    if ({done_predict, done_newlm, done_update} != 3'b000) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got %b want none", {done_predict, done_newlm, done_update});
      end else begin
        e = sbq.pop_front();
        chk("done_vec", 16'({done_predict, done_newlm, done_update}), 16'(e.d));
        chk("latency", 16'(cyc), 16'(e.due));
        chk("busy_at_done", 16'(busy), 16'h0);
        for (int i = 0; i < 6; i++) chk($sformatf("r%0d", i), got[i], e.r[i]);
      end
    end
  end
  initial begin
    {init_predict, init_newlm, init_update} = '0;
    {xk, yk, xita, lkx, lky, vdt, wdt, obs_r, obs_phi} = '0;
    sys_rst = 1'b1;
    idle(3);
    chk("rst_done", 16'({done_predict, done_newlm, done_update}), 16'h0);
    chk("rst_res", result_0 | result_1 | result_2 | result_3 | result_4 | result_5, 16'h0);
    chk("rst_busy", 16'(busy), 16'h0);
    chk("rst_err", 16'(err_overlap), 16'h0);
    sys_rst = 1'b0;
    idle(1);
    xk = 16'h0100; yk = 16'h0200; xita = 16'h0000; vdt = 16'h0080; wdt = 16'h0100;
    go(3'b100, 1'b1, 3'b100, {16'h0, 16'h0080, 16'h0000, 16'h0100, 16'h0200, 16'h0180});
    chk("busy_inflight", 16'(busy), 16'h1);
    idle(5);
    xita = 16'h4000;
    go(3'b100, 1'b1, 3'b100, {16'h0, 16'h0000, 16'hFF80, 16'h4100, 16'h0280, 16'h0100});
    idle(5);
    xk = 16'h7F00; vdt = 16'h0200; xita = 16'hFF00; wdt = 16'h0200;
    go(3'b100, 1'b1, 3'b100, {16'h0, 16'h0200, 16'h000D, 16'h0100, 16'h01F3, 16'h7FFF});
    idle(5);
    chk("hold_r0", result_0, 16'h7FFF);
    chk("err_clean", 16'(err_overlap), 16'h0);
    lkx = 16'h0400; xk = 16'h0100; lky = 16'h0100; yk = 16'h0500;
    go(3'b001, 1'b1, 3'b001, {16'h0, 16'h0, 16'h0, 16'h1900, 16'hFC00, 16'h0300});
    idle(5);
    xk = 16'h0100; yk = 16'h0200; xita = 16'h3000; obs_phi = 16'h1000; obs_r = 16'h0100;
    go(3'b010, 1'b1, 3'b010, {16'h0, 16'h4000, 16'h0000, 16'h4000, 16'h0300, 16'h0100});
    idle(5);
    chk("err_clean2", 16'(err_overlap), 16'h0);
    xita = 16'h0000; vdt = 16'h0080; wdt = 16'h0100;
    go(3'b101, 1'b1, 3'b100, {16'h0, 16'h0080, 16'h0000, 16'h0100, 16'h0200, 16'h0180});
    chk("err_arb", 16'(err_overlap), 16'h1);
    go(3'b010, 1'b0, 3'b000, '0);
    idle(5);
    go(3'b100, 1'b0, 3'b000, '0);
    idle(1);
    sys_rst = 1'b1;
    idle(2);
    chk("midrst_done", 16'({done_predict, done_newlm, done_update}), 16'h0);
    chk("midrst_res", result_0 | result_1 | result_2 | result_3 | result_4 | result_5, 16'h0);
    chk("midrst_busy", 16'(busy), 16'h0);
    chk("midrst_err", 16'(err_overlap), 16'h0);
    sys_rst = 1'b0;
    idle(6);
    chk("no_done_after_rst", 16'(sbq.size()), 16'h0);
    xita = 16'h0000; obs_phi = 16'h0000; obs_r = 16'h0100; xk = 16'h0100; yk = 16'h0200;
    go(3'b010, 1'b1, 3'b010, {16'h0, 16'h0000, 16'h4000, 16'h0000, 16'h0200, 16'h0200});
    chk("err_before_busy_req", 16'(err_overlap), 16'h0);
    go(3'b001, 1'b0, 3'b000, '0);
    chk("err_busy_req", 16'(err_overlap), 16'h1);
    idle(15);
    chk("queue_empty", 16'(sbq.size()), 16'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
